// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - pending register-write scoreboard with ID stall generation
// Issue side in ID, retire side in WB, squash side in EX; r0 and out-of-range addresses are never tracked.
module reg_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int CW   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] RsAddr_id,
  input  logic [AW-1:0] RtAddr_id,
  input  logic          RtUsed_id,
  input  logic          IssueValid,
  input  logic          IssueWe,
  input  logic [AW-1:0] IssueAddr,
  input  logic          RegWrite_wb,
  input  logic [AW-1:0] RegWriteAddr_wb,
  input  logic          KillWe,
  input  logic [AW-1:0] KillAddr,
  output logic          Stall,
  output logic          IssueAccept,
  output logic          PendingAny,
  output logic          ErrOvf,
  output logic          ErrUnf
);

  localparam logic [CW-1:0] MAXC = '1;

  logic [CW-1:0] cnt     [NREG];
  logic [CW-1:0] cntNext [NREG];

  logic          wbOk, killOk, issueOk, issueFire;
  logic [CW-1:0] rsCnt, rtCnt, issCnt;
  logic          hazRs, hazRt, ovfHold;
  logic          ovfAny, unfAny, anyPend;

  function automatic logic addrOk(input logic [AW-1:0] a);
    return (a != '0) && (32'(a) < 32'(NREG));
  endfunction

  always_comb begin
    wbOk    = RegWrite_wb && addrOk(RegWriteAddr_wb);
    killOk  = KillWe && addrOk(KillAddr);
    issueOk = IssueWe && addrOk(IssueAddr);
    rsCnt   = addrOk(RsAddr_id) ? cnt[RsAddr_id] : '0;
    rtCnt   = addrOk(RtAddr_id) ? cnt[RtAddr_id] : '0;
    issCnt  = issueOk ? cnt[IssueAddr] : '0;
    // A lone pending write retiring this cycle is supplied by WB forwarding.
    hazRs   = (rsCnt != '0) &&
              !((rsCnt == CW'(1)) && wbOk && (RegWriteAddr_wb == RsAddr_id));
    hazRt   = (rtCnt != '0) &&
              !((rtCnt == CW'(1)) && wbOk && (RegWriteAddr_wb == RtAddr_id));
    ovfHold = issueOk && (issCnt == MAXC) &&
              !(wbOk && (RegWriteAddr_wb == IssueAddr)) &&
              !(killOk && (KillAddr == IssueAddr));
    Stall       = IssueValid && (hazRs || (RtUsed_id && hazRt) || ovfHold);
    IssueAccept = IssueValid && !Stall;
    issueFire   = IssueAccept && issueOk;
  end

  // Counters are evaluated with a +2 bias so the -2..+1 delta stays unsigned.
  always_comb begin : nextCalc
    logic [CW+1:0] sum;
    sum     = '0;
    ovfAny  = 1'b0;
    unfAny  = 1'b0;
    anyPend = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      sum = {2'b00, cnt[r]} + (CW+2)'(2)
          + (CW+2)'(issueFire && (IssueAddr == AW'(r)))
          - (CW+2)'(wbOk && (RegWriteAddr_wb == AW'(r)))
          - (CW+2)'(killOk && (KillAddr == AW'(r)));
      if (sum < (CW+2)'(2)) begin
        cntNext[r] = '0;
        unfAny     = 1'b1;
      end else if (sum > ((CW+2)'(MAXC) + (CW+2)'(2))) begin
        cntNext[r] = MAXC;
        ovfAny     = 1'b1;
      end else begin
        cntNext[r] = CW'(sum - (CW+2)'(2));
      end
      anyPend = anyPend || (cnt[r] != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      PendingAny <= 1'b0;
      ErrOvf     <= 1'b0;
      ErrUnf     <= 1'b0;
    end else begin
      cnt        <= cntNext;
      PendingAny <= anyPend;
      ErrOvf     <= ErrOvf || ovfAny;
      ErrUnf     <= ErrUnf || unfAny;
    end
  end

endmodule
